writeback_stage: RTL and testbench

Writeback stage of the pipelined Y86-64 core: the writer side of the decode-stage register file. Holds the W pipeline register, turns the retiring instruction into the register file's two write ports (E and M), exports the same values as forwarding sources to decode, and runs the processor status machine that stops the core on halt or exception. Sits between the memory stage and the register file / decode forwarding logic.

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/writeback_stage_if.sv | 41 ++++
 rtl/wb_status_fsm.sv | 49 ++++
 rtl/writeback_stage.sv | 65 ++++++
 tb/tb_writeback_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: ISA-level constants and types shared by the fetch, decode,
// memory and writeback stages of the pipelined Y86-64 core.
//   - icode constants (I_*)
//   - register IDs, including RSP and RNONE ("no register")
//   - stat codes (STAT_*)
//   - w_reg_t: the W pipeline register, and W_BUBBLE: its bubble value
//   - wb_state_t: the writeback status FSM state encoding
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [2:0] STAT_BUB = 3'd0;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [63:0] val_e;
      logic [63:0] val_m;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } w_reg_t;

   localparam w_reg_t W_BUBBLE = '{
      stat:  STAT_BUB,
      icode: I_NOP,
      val_e: 64'd0,
      val_m: 64'd0,
      dst_e: RNONE,
      dst_m: RNONE
   };

   typedef enum logic [0:0] {
      WB_RUN    = 1'b0,
      WB_HALTED = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundle between the memory stage / pipeline control
// (master) and the writeback stage (slave).
//   master drives: M_* instruction fields, m_valM, W_stall, W_bubble
//   slave drives:  w_dstE/w_valE/w_dstM/w_valM (register-file write ports
//                  and decode forwarding sources), W_icode, Stat, halted,
//                  retired, wb_state (status FSM state, for debug/checkers)
// There is no valid/ready handshake here: the M inputs are sampled on every
// rising edge unless W_stall holds the register or the core is halted.
interface writeback_stage_if;
   import y86_pkg::*;

   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic [63:0] M_valE;
   logic [63:0] m_valM;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic        W_stall;
   logic        W_bubble;

   logic [3:0]  w_dstE;
   logic [63:0] w_valE;
   logic [3:0]  w_dstM;
   logic [63:0] w_valM;
   logic [3:0]  W_icode;
   logic [2:0]  Stat;
   logic        halted;
   logic [63:0] retired;
   wb_state_t   wb_state;

   modport master (
      output M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM, W_stall, W_bubble,
      input  w_dstE, w_valE, w_dstM, w_valM, W_icode, Stat, halted, retired, wb_state
   );

   modport slave (
      input  M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM, W_stall, W_bubble,
      output w_dstE, w_valE, w_dstM, w_valM, W_icode, Stat, halted, retired, wb_state
   );

endinterface

// File: rtl/wb_status_fsm.sv
// wb_status_fsm: processor status machine and retirement counter.
//   clk, rst_n : clock, async active-low reset
//   w_stat     : stat of the instruction currently in W
//   stat       : processor status (AOK while running, latched fault code after)
//   halted     : core stopped
//   retired    : count of retired (AOK) instructions, wraps modulo 2^64
//   state      : current FSM state
// HALTED is absorbing; only reset leaves it.
module wb_status_fsm
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  w_stat,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] retired,
   output wb_state_t   state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= WB_RUN;
         stat    <= STAT_AOK;
         halted  <= 1'b0;
         retired <= 64'd0;
      end else begin
         case (state)
            WB_RUN: begin
               if (w_stat == STAT_AOK)
                  retired <= retired + 64'd1;
               // BUB and AOK keep running; any other code stops the core.
               if (w_stat == STAT_HLT || w_stat == STAT_ADR || w_stat == STAT_INS) begin
                  state  <= WB_HALTED;
                  stat   <= w_stat;
                  halted <= 1'b1;
               end
            end
            WB_HALTED: begin
               state <= WB_HALTED;
            end
            default: begin
               state <= WB_HALTED;
            end
         endcase
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: W pipeline register and register-file write ports.
//   clk, rst_n : clock, async active-low reset
//   wb (slave) : M-stage inputs and W_stall/W_bubble in; register-file
//                write ports, W_icode, Stat, halted, retired, wb_state out
// Write ports are combinational from W and the status FSM only.
module writeback_stage
   import y86_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   writeback_stage_if.slave   wb
);

   w_reg_t      w_q;
   logic        halted;
   logic [2:0]  stat;
   logic [63:0] retired;
   wb_state_t   state;
   logic        wr_en;

   wb_status_fsm u_status (
      .clk     (clk),
      .rst_n   (rst_n),
      .w_stat  (w_q.stat),
      .stat    (stat),
      .halted  (halted),
      .retired (retired),
      .state   (state)
   );

   // Halted freezes W; stall beats bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q <= W_BUBBLE;
      end else if (halted || wb.W_stall) begin
         w_q <= w_q;
      end else if (wb.W_bubble) begin
         w_q <= W_BUBBLE;
      end else begin
         w_q.stat  <= wb.M_stat;
         w_q.icode <= wb.M_icode;
         w_q.val_e <= wb.M_valE;
         w_q.val_m <= wb.m_valM;
         w_q.dst_e <= wb.M_dstE;
         w_q.dst_m <= wb.M_dstM;
      end
   end

   assign wr_en = (state == WB_RUN) && (w_q.stat == STAT_AOK);

   // When both ports target the same register the M write wins
   // (popq %rsp must leave the popped value, not the incremented pointer).
   assign wb.w_dstE = (wr_en && !(w_q.dst_e == w_q.dst_m && w_q.dst_m != RNONE))
                      ? w_q.dst_e : RNONE;
   assign wb.w_dstM = wr_en ? w_q.dst_m : RNONE;
   assign wb.w_valE = w_q.val_e;
   assign wb.w_valM = w_q.val_m;

   assign wb.W_icode  = w_q.icode;
   assign wb.Stat     = stat;
   assign wb.halted   = halted;
   assign wb.retired  = retired;
   assign wb.wb_state = state;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors for writeback_stage with
// hand-computed expected values.
module tb_writeback_stage;
   import y86_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;

   writeback_stage_if wb ();

   writeback_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checking
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm);
      wb.M_stat  = st;
      wb.M_icode = ic;
      wb.M_valE  = ve;
      wb.m_valM  = vm;
      wb.M_dstE  = de;
      wb.M_dstM  = dm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      wb.W_stall  = 1'b0;
      wb.W_bubble = 1'b0;
      drive(STAT_BUB, I_NOP, 64'd0, 64'd0, RNONE, RNONE);
      rst_n = 1'b0;
      #12;
      check("rst_w_dstE",  64'(wb.w_dstE), 64'hF);
      check("rst_w_dstM",  64'(wb.w_dstM), 64'hF);
      check("rst_stat",    64'(wb.Stat), 64'd1);
      check("rst_halted",  64'(wb.halted), 64'd0);
      check("rst_retired", wb.retired, 64'd0);
      check("rst_icode",   64'(wb.W_icode), 64'h1);
      check("rst_state",   64'(wb.wb_state), 64'(WB_RUN));
      #2 rst_n = 1'b1;

      // three irmovq
      drive(STAT_AOK, I_IRMOVQ, 64'd5, 64'd0, 4'd0, RNONE); tick();
      check("irm0_dstE", 64'(wb.w_dstE), 64'd0);
      check("irm0_valE", wb.w_valE, 64'd5);
      check("irm0_dstM", 64'(wb.w_dstM), 64'hF);
      drive(STAT_AOK, I_IRMOVQ, 64'd6, 64'd0, 4'd1, RNONE); tick();
      check("irm1_dstE", 64'(wb.w_dstE), 64'd1);
      check("irm1_valE", wb.w_valE, 64'd6);
      check("irm1_ret",  wb.retired, 64'd1);
      drive(STAT_AOK, I_IRMOVQ, 64'd7, 64'd0, 4'd2, RNONE); tick();
      check("irm2_dstE", 64'(wb.w_dstE), 64'd2);
      check("irm2_valE", wb.w_valE, 64'd7);

      // popq %rsp
      drive(STAT_AOK, I_POPQ, 64'h108, 64'h55, RSP, RSP); tick();
      check("irm_ret3",  wb.retired, 64'd3);
      check("pop_dstE",  64'(wb.w_dstE), 64'hF);
      check("pop_dstM",  64'(wb.w_dstM), 64'd4);
      check("pop_valM",  wb.w_valM, 64'h55);

      // mrmovq to reg 3, then stall for two cycles
      drive(STAT_AOK, I_MRMOVQ, 64'h20, 64'hAA, RNONE, 4'd3); tick();
      check("mrm_dstM",  64'(wb.w_dstM), 64'd3);
      check("mrm_ret",   wb.retired, 64'd4);
      wb.W_stall = 1'b1;
      drive(STAT_AOK, I_IRMOVQ, 64'd9, 64'd0, 4'd7, RNONE); tick();
      check("stl1_dstM", 64'(wb.w_dstM), 64'd3);
      check("stl1_valM", wb.w_valM, 64'hAA);
      check("stl1_dstE", 64'(wb.w_dstE), 64'hF);
      wb.W_bubble = 1'b1;   // stall must beat bubble
      tick();
      check("stl2_dstM", 64'(wb.w_dstM), 64'd3);
      check("stl2_icode", 64'(wb.W_icode), 64'(I_MRMOVQ));
      check("stl2_ret",  wb.retired, 64'd6);
      wb.W_stall = 1'b0;
      tick();
      check("bub_dstE",  64'(wb.w_dstE), 64'hF);
      check("bub_dstM",  64'(wb.w_dstM), 64'hF);
      check("bub_icode", 64'(wb.W_icode), 64'(I_NOP));
      check("bub_ret1",  wb.retired, 64'd7);
      tick();
      check("bub_ret2",  wb.retired, 64'd7);
      wb.W_bubble = 1'b0;

      // addq then halt
      drive(STAT_AOK, I_OPQ, 64'h30, 64'd0, 4'd2, RNONE); tick();
      check("add_dstE",  64'(wb.w_dstE), 64'd2);
      check("add_valE",  wb.w_valE, 64'h30);
      drive(STAT_HLT, I_HALT, 64'd0, 64'd0, RNONE, RNONE); tick();
      check("hlt_dstE",  64'(wb.w_dstE), 64'hF);
      check("hlt_dstM",  64'(wb.w_dstM), 64'hF);
      check("hlt_halt0", 64'(wb.halted), 64'd0);
      check("hlt_stat0", 64'(wb.Stat), 64'd1);
      check("hlt_ret",   wb.retired, 64'd8);
      drive(STAT_AOK, I_IRMOVQ, 64'h99, 64'd0, 4'd5, RNONE); tick();
      check("hlt_halt1", 64'(wb.halted), 64'd1);
      check("hlt_stat1", 64'(wb.Stat), 64'd2);
      check("hlt_state", 64'(wb.wb_state), 64'(WB_HALTED));
      check("hlt_wr",    64'(wb.w_dstE), 64'hF);
      drive(STAT_AOK, I_OPQ, 64'h1234, 64'd0, 4'd6, RNONE); tick();
      tick();
      check("frz_icode", 64'(wb.W_icode), 64'(I_IRMOVQ));
      check("frz_valE",  wb.w_valE, 64'h99);
      check("frz_ret",   wb.retired, 64'd8);
      check("frz_stat",  64'(wb.Stat), 64'd2);

      // async reset between edges while halted
      rst_n = 1'b0;
      #2;
      check("arst_halt", 64'(wb.halted), 64'd0);
      check("arst_stat", 64'(wb.Stat), 64'd1);
      check("arst_ret",  wb.retired, 64'd0);
      check("arst_dstE", 64'(wb.w_dstE), 64'hF);
      #1 rst_n = 1'b1;

      // resume, then an ADR fault with dstM = 6
      drive(STAT_AOK, I_IRMOVQ, 64'd11, 64'd0, 4'd1, RNONE); tick();
      check("res_dstE",  64'(wb.w_dstE), 64'd1);
      check("res_valE",  wb.w_valE, 64'd11);
      drive(STAT_ADR, I_MRMOVQ, 64'd0, 64'h77, RNONE, 4'd6); tick();
      check("adr_ret",   wb.retired, 64'd1);
      check("adr_dstM",  64'(wb.w_dstM), 64'hF);
      check("adr_halt0", 64'(wb.halted), 64'd0);
      drive(STAT_AOK, I_IRMOVQ, 64'd3, 64'd0, 4'd2, RNONE); tick();
      check("adr_halt1", 64'(wb.halted), 64'd1);
      check("adr_stat",  64'(wb.Stat), 64'd3);
      check("adr_ret2",  wb.retired, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
